// File: rtl/debug_access_arbiter_pkg.sv
// Shared definitions for the debug access path: target encoding, FSM states
// and the response width used by all debug read ports.
package debug_access_arbiter_pkg;

  localparam int RSP_W      = 16;
  localparam int REQ_ADDR_W = 12;

  typedef enum logic [1:0] {
    REG  = 2'd0,
    IMEM = 2'd1,
    DMEM = 2'd2
  } dbg_target_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    READ   = 2'd2,
    RESP   = 2'd3
  } dbg_state_t;

  // 2'b10 imem, 2'b11 dmem, anything with a zero MSB is the register file.
  function automatic dbg_target_t decode_target(input logic [1:0] sel);
    case (sel)
      2'b10:   return IMEM;
      2'b11:   return DMEM;
      default: return REG;
    endcase
  endfunction

endpackage

// File: rtl/debug_access_arbiter_rr.sv
// Two-way round-robin grant; the pointer moves only when a grant is consumed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] request,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio;

  always_comb begin
    grant = request;
    if (request == 2'b11) grant = prio ? 2'b10 : 2'b01;
  end

  // Whoever was just served loses priority on the next tie.
  always_ff @(posedge clk) begin
    if (reset) prio <= 1'b0;
    else if (advance) prio <= grant[0];
  end

endmodule

// File: rtl/debug_access_arbiter.sv
// Debug read arbiter: grants one of two requesters, halts the CPU, settles,
// reads register file / imem / dmem and returns a one-cycle response.
module debug_access_arbiter
  import debug_access_arbiter_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int INST_W      = 16,
  parameter int D_ADDR_W    = 12,
  parameter int I_ADDR_W    = 12,
  parameter int HALT_CYCLES = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [3:0]          req_target,
  input  logic [23:0]         req_addr,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [RSP_W-1:0]    rsp_data,
  output logic                debug_enable,
  output logic [3:0]          reg_debug_addr,
  input  logic [DATA_W-1:0]   reg_debug_rdata,
  output logic [D_ADDR_W-1:0] dmem_debug_addr,
  input  logic [DATA_W-1:0]   dmem_debug_rdata,
  output logic [I_ADDR_W-1:0] imem_debug_addr,
  input  logic [INST_W-1:0]   imem_debug_rdata
);

  localparam int CNT_W = 8;

  dbg_state_t              state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              grant, owner;
  logic                    xfer;
  logic [1:0]              sel_target;
  logic [REQ_ADDR_W-1:0]   sel_addr, addr_q;
  dbg_target_t             tgt_q;
  logic [RSP_W-1:0]        rdata_sel;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .request (req_valid),
    .advance (xfer),
    .grant   (grant)
  );

  assign xfer       = |req_ready;
  assign sel_target = grant[1] ? req_target[3:2] : req_target[1:0];
  assign sel_addr   = grant[1] ? req_addr[23:12] : req_addr[11:0];

  assign reg_debug_addr  = addr_q[3:0];
  assign dmem_debug_addr = D_ADDR_W'(addr_q);
  assign imem_debug_addr = I_ADDR_W'(addr_q);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = (HALT_CYCLES == 0) ? READ : SETTLE;
      SETTLE:  if (cnt == '0) state_next = READ;
      READ:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = xfer ? READ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is combinational so a waiting requester is accepted the same cycle.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (!reset) begin
      if (state == IDLE || state == RESP) req_ready = grant & req_valid;
      if (state == RESP) rsp_valid = owner;
    end
  end

  always_comb begin
    case (tgt_q)
      IMEM:    rdata_sel = RSP_W'(imem_debug_rdata);
      DMEM:    rdata_sel = RSP_W'(dmem_debug_rdata);
      default: rdata_sel = RSP_W'(reg_debug_rdata);
    endcase
  end

  // One down-counter serves both the settle and the read phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      owner        <= 2'b00;
      addr_q       <= '0;
      tgt_q        <= REG;
      rsp_data     <= '0;
      debug_enable <= 1'b0;
    end else begin
      debug_enable <= (state_next != IDLE);
      if (xfer) begin
        owner  <= grant;
        addr_q <= sel_addr;
        tgt_q  <= decode_target(sel_target);
      end
      if (state_next == SETTLE && state != SETTLE) cnt <= CNT_W'(HALT_CYCLES - 1);
      else if (state_next == READ && state != READ) cnt <= CNT_W'(RD_LATENCY - 1);
      else if (cnt != '0) cnt <= cnt - 1'b1;
      if (state == READ && cnt == '0) rsp_data <= rdata_sel;
    end
  end

endmodule

// File: tb/tb_debug_access_arbiter.sv
// Directed bench for debug_access_arbiter: default build plus a
// HALT_CYCLES=0 / RD_LATENCY=3 build, responses checked through scoreboards.
module tb_debug_access_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  logic [1:0]  req_valid, req_ready, rsp_valid;
  logic [3:0]  req_target;
  logic [23:0] req_addr;
  logic [15:0] rsp_data;
  logic        debug_enable;
  logic [3:0]  reg_debug_addr;
  logic [7:0]  reg_debug_rdata, dmem_debug_rdata;
  logic [11:0] dmem_debug_addr, imem_debug_addr;
  logic [15:0] imem_debug_rdata;

  logic [1:0]  b_req_valid, b_req_ready, b_rsp_valid;
  logic [3:0]  b_req_target;
  logic [23:0] b_req_addr;
  logic [15:0] b_rsp_data;
  logic        b_debug_enable;
  logic [3:0]  b_reg_debug_addr;
  logic [7:0]  b_reg_debug_rdata, b_dmem_debug_rdata;
  logic [11:0] b_dmem_debug_addr, b_imem_debug_addr;
  logic [15:0] b_imem_debug_rdata;

  typedef struct {
    int          req;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  debug_access_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_target(req_target), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .debug_enable(debug_enable),
    .reg_debug_addr(reg_debug_addr), .reg_debug_rdata(reg_debug_rdata),
    .dmem_debug_addr(dmem_debug_addr), .dmem_debug_rdata(dmem_debug_rdata),
    .imem_debug_addr(imem_debug_addr), .imem_debug_rdata(imem_debug_rdata)
  );

  debug_access_arbiter #(.HALT_CYCLES(0), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_target(b_req_target), .req_addr(b_req_addr),
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .debug_enable(b_debug_enable),
    .reg_debug_addr(b_reg_debug_addr), .reg_debug_rdata(b_reg_debug_rdata),
    .dmem_debug_addr(b_dmem_debug_addr), .dmem_debug_rdata(b_dmem_debug_rdata),
    .imem_debug_addr(b_imem_debug_addr), .imem_debug_rdata(b_imem_debug_rdata)
  );

  // Memory models for the default build
  assign reg_debug_rdata  = {4'h3, reg_debug_addr};
  assign dmem_debug_rdata = (dmem_debug_addr == 12'h123) ? 8'hA5 : (dmem_debug_addr[7:0] ^ 8'h5A);
  assign imem_debug_rdata = (imem_debug_addr == 12'h010) ? 16'hBEEF : {4'hC, imem_debug_addr};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int i, input string tag, output int t);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(req_ready[i]), 32'd1);
    t = cyc;
  endtask

  task automatic drain(input bit use_b, input string tag);
    int n;
    n = 0;
    while ((use_b ? qb.size() : qa.size()) > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(use_b ? qb.size() : qa.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rsp_valid !== 2'b00) begin
      if (qa.size() == 0) check("rsp_a_unexpected", 32'(rsp_valid), 32'd0);
      else begin : pop_a
        exp_t e;
        e = qa.pop_front();
        check("rsp_a_who", 32'(rsp_valid), 32'(1) << e.req);
        check("rsp_a_data", 32'(rsp_data), 32'(e.data));
        check("rsp_a_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (b_rsp_valid !== 2'b00) begin
      if (qb.size() == 0) check("rsp_b_unexpected", 32'(b_rsp_valid), 32'd0);
      else begin : pop_b
        exp_t e;
        e = qb.pop_front();
        check("rsp_b_who", 32'(b_rsp_valid), 32'(1) << e.req);
        check("rsp_b_data", 32'(b_rsp_data), 32'(e.data));
        check("rsp_b_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int t, r, prev_t, prev_lat;
    req_valid = 2'b01; req_target = 4'b1111; req_addr = 24'h0;
    b_req_valid = 2'b00; b_req_target = 4'b0; b_req_addr = 24'h0;
    b_reg_debug_rdata = 8'h00; b_dmem_debug_rdata = 8'h00; b_imem_debug_rdata = 16'h0;

    // Reset state, with a request pending to prove ready stays low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_den", 32'(debug_enable), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_reg_addr", 32'(reg_debug_addr), 32'd0);
    check("rst_dmem_addr", 32'(dmem_debug_addr), 32'd0);
    check("rst_imem_addr", 32'(imem_debug_addr), 32'd0);
    check("rst_b_den", 32'(b_debug_enable), 32'd0);
    req_valid = 2'b00;
    step();
    reset = 1'b0;

    // Single dmem request
    step();
    req_target = 4'b0011; req_addr = {12'h0, 12'h123}; req_valid = 2'b01;
    wait_ready(0, "single_ready", t);
    check("single_den_at_T", 32'(debug_enable), 32'd0);
    qa.push_back('{0, 16'h00A5, t + 4});
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("single_den_T1", 32'(debug_enable), 32'd1);
    check("single_dmem_addr", 32'(dmem_debug_addr), 32'h123);
    check("single_reg_addr", 32'(reg_debug_addr), 32'h3);
    drain(1'b0, "single_drain");

    // Back-to-back: second request waits, then is taken in RESP
    step();
    req_target = 4'b0000; req_addr = {12'h0, 12'h005}; req_valid = 2'b01;
    wait_ready(0, "b2b_first", t);
    qa.push_back('{0, 16'h0035, t + 4});
    step();
    req_target = 4'b0010; req_addr = {12'h0, 12'h010};
    wait_ready(0, "b2b_second", r);
    check("b2b_in_resp", 32'(r), 32'(t + 4));
    qa.push_back('{0, 16'hBEEF, r + 2});
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("b2b_den_r1", 32'(debug_enable), 32'd1);
    @(negedge clk);
    check("b2b_den_r2", 32'(debug_enable), 32'd1);
    drain(1'b0, "b2b_drain");

    // Late arrival of requester 1 during READ of requester 0
    step();
    req_target = 4'b0011; req_addr = {12'h0, 12'h040}; req_valid = 2'b01;
    wait_ready(0, "late_first", t);
    qa.push_back('{0, 16'h001A, t + 4});
    step();
    req_valid = 2'b00;
    step();
    step();
    req_target = 4'b1011; req_addr = {12'h055, 12'h040}; req_valid = 2'b10;
    @(negedge clk);
    check("late_wait_in_read", 32'(req_ready), 32'd0);
    wait_ready(1, "late_ready", r);
    check("late_in_resp", 32'(r), 32'(t + 4));
    qa.push_back('{1, 16'hC055, r + 2});
    step();
    req_valid = 2'b00;
    drain(1'b0, "late_drain");

    // Reset in the READ cycle aborts the access
    step();
    req_target = 4'b0011; req_addr = {12'h0, 12'h123}; req_valid = 2'b01;
    wait_ready(0, "abort_ready", t);
    step();
    req_valid = 2'b00;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("abort_den", 32'(debug_enable), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_data", 32'(rsp_data), 32'd0);
    repeat (4) @(negedge clk);

    // Contention after reset: 0,1,0,1 with full latency on the first
    step();
    req_target = 4'b0000; req_addr = {12'h007, 12'h003}; req_valid = 2'b11;
    prev_t = 0; prev_lat = 0;
    for (int k = 0; k < 4; k++) begin
      int who, lat;
      who = k % 2;
      lat = (k == 0) ? 4 : 2;
      wait_ready(who, "cont_ready", t);
      check("cont_grant", 32'(req_ready), 32'(1) << who);
      if (k == 0) check("cont_den_idle", 32'(debug_enable), 32'd0);
      else check("cont_b2b_cycle", 32'(t), 32'(prev_t + prev_lat));
      qa.push_back('{who, (who == 1) ? 16'h0037 : 16'h0033, t + lat});
      prev_t = t; prev_lat = lat;
    end
    step();
    req_valid = 2'b00;
    drain(1'b0, "cont_drain");

    // HALT_CYCLES=0, RD_LATENCY=3 build: only the third READ cycle's data counts
    step();
    b_req_target = 4'b0011; b_req_addr = {12'h0, 12'h123}; b_req_valid = 2'b01;
    begin : wait_b
      int n;
      n = 0;
      @(negedge clk);
      while (b_req_ready[0] !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b_ready", 32'(b_req_ready[0]), 32'd1);
      t = cyc;
    end
    qb.push_back('{0, 16'h00A5, t + 4});
    step();
    b_req_valid = 2'b00; b_dmem_debug_rdata = 8'h11;
    @(negedge clk);
    check("b_den_T1", 32'(b_debug_enable), 32'd1);
    check("b_dmem_addr", 32'(b_dmem_debug_addr), 32'h123);
    step();
    b_dmem_debug_rdata = 8'h22;
    step();
    b_dmem_debug_rdata = 8'hA5;
    step();
    b_dmem_debug_rdata = 8'hEE;
    drain(1'b1, "b_drain");
    repeat (3) @(negedge clk);
    check("final_qa_empty", 32'(qa.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
